pan_tilt_servo_ctrl: RTL and testbench

PAN_TILT_SERVO_CTRL -- requirements
Module: pan_tilt_servo_ctrl

---
 rtl/pan_tilt_servo_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pan_tilt_servo_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pan_tilt_servo_ctrl.sv
// Pan/tilt servo controller: steers two 50 Hz servo PWM channels toward a tracked
// target centroid, holds on target loss and slews home after a timeout.
module pan_tilt_servo_ctrl #(
  parameter int unsigned CLK_PER_US  = 100,
  parameter int unsigned PERIOD_US   = 20000,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned MAX_US      = 2000,
  parameter int unsigned CENTER_US   = 1500,
  parameter int unsigned CX          = 320,
  parameter int unsigned CY          = 240,
  parameter int unsigned DEADBAND    = 16,
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned MAX_STEP    = 20,
  parameter int unsigned LOST_FRAMES = 30,
  parameter int unsigned RETURN_STEP = 10,
  parameter bit          PAN_INV     = 1'b0,
  parameter bit          TILT_INV    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  input  logic        aim_detected,
  input  logic        track_en,
  output logic        pan_pwm,
  output logic        tilt_pwm,
  output logic [10:0] pan_us,
  output logic [10:0] tilt_us,
  output logic [1:0]  state,
  output logic        on_target
);

  localparam logic [10:0] MinUs     = 11'(MIN_US);
  localparam logic [10:0] MaxUs     = 11'(MAX_US);
  localparam logic [10:0] CenterUs  = 11'(CENTER_US);
  localparam logic [10:0] Deadband  = 11'(DEADBAND);
  localparam logic [10:0] MaxStep   = 11'(MAX_STEP);
  localparam logic [10:0] RetStep   = 11'(RETURN_STEP);
  localparam logic [5:0]  LostMax   = 6'(LOST_FRAMES);
  localparam logic signed [10:0] CxS = 11'(CX);
  localparam logic signed [10:0] CyS = 11'(CY);
  localparam logic [15:0] PrescMax  = 16'(CLK_PER_US - 1);
  localparam logic [15:0] UsMax     = 16'(PERIOD_US - 1);

  typedef enum logic [1:0] {StTrack = 2'd0, StHold = 2'd1, StReturn = 2'd2} state_e;

  function automatic logic [10:0] magnitude(input logic signed [10:0] err);
    logic [10:0] m;
    if (err[10]) m = 11'(-err);
    else         m = 11'(err);
    return m;
  endfunction

  function automatic logic [10:0] track_axis(input logic [10:0] pos,
                                             input logic signed [10:0] err,
                                             input logic inv);
    logic [10:0] mag, sh, step, res;
    logic [11:0] up_sum;
    mag = magnitude(err);
    sh  = mag >> SHIFT;
    if (sh == 11'd0)      step = 11'd1;
    else if (sh > MaxStep) step = MaxStep;
    else                  step = sh;
    up_sum = {1'b0, pos} + {1'b0, step};
    res = pos;
    if (mag > Deadband) begin
      if (err[10] == inv) res = (up_sum > {1'b0, MaxUs}) ? MaxUs : up_sum[10:0];
      else res = ({1'b0, pos} < ({1'b0, MinUs} + {1'b0, step})) ? MinUs : pos - step;
    end
    return res;
  endfunction

  function automatic logic [10:0] return_axis(input logic [10:0] pos);
    logic [10:0] res;
    res = pos;
    if (pos > CenterUs)      res = ((pos - CenterUs) > RetStep) ? pos - RetStep : CenterUs;
    else if (pos < CenterUs) res = ((CenterUs - pos) > RetStep) ? pos + RetStep : CenterUs;
    return res;
  endfunction

  // vsync synchroniser; armed_q blocks an edge from a vsync already high at reset release
  logic       vs1_q, vs2_q, vs3_q, armed_q;
  logic [1:0] vld_q;
  logic       evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs1_q   <= 1'b0;
      vs2_q   <= 1'b0;
      vs3_q   <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      vs1_q   <= vsync_in;
      vs2_q   <= vs1_q;
      vs3_q   <= vs2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~vs2_q);
    end
  end

  assign evt = vs2_q & ~vs3_q & armed_q;

  state_e             st_q, st_d;
  logic [5:0]         lost_q, lost_d, lost_inc;
  logic [10:0]        pan_q, pan_d, tilt_q, tilt_d;
  logic               on_q, on_d;
  logic signed [10:0] err_x, err_y;

  always_comb begin
    st_d     = st_q;
    lost_d   = lost_q;
    pan_d    = pan_q;
    tilt_d   = tilt_q;
    on_d     = on_q;
    err_x    = $signed({1'b0, aim_x}) - CxS;
    err_y    = $signed({1'b0, aim_y}) - CyS;
    lost_inc = (lost_q == 6'h3f) ? lost_q : lost_q + 6'd1;
    if (!track_en) begin
      on_d = 1'b0;
    end else if (evt) begin
      on_d = aim_detected && (magnitude(err_x) <= Deadband) && (magnitude(err_y) <= Deadband);
      if (aim_detected) begin
        st_d   = StTrack;
        lost_d = 6'd0;
        pan_d  = track_axis(pan_q, err_x, PAN_INV);
        tilt_d = track_axis(tilt_q, err_y, TILT_INV);
      end else begin
        unique case (st_q)
          StTrack, StHold: begin
            lost_d = lost_inc;
            st_d   = (lost_inc >= LostMax) ? StReturn : StHold;
          end
          StReturn: begin
            pan_d  = return_axis(pan_q);
            tilt_d = return_axis(tilt_q);
          end
          default: st_d = StTrack;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= StTrack;
      lost_q <= 6'd0;
      pan_q  <= CenterUs;
      tilt_q <= CenterUs;
      on_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      lost_q <= lost_d;
      pan_q  <= pan_d;
      tilt_q <= tilt_d;
      on_q   <= on_d;
    end
  end

  // PWM frame timing; widths are only sampled at the frame wrap
  logic [15:0] presc_q, presc_d, us_q, us_d;
  logic [10:0] wpan_q, wpan_d, wtilt_q, wtilt_d;
  logic        pan_pwm_q, pan_pwm_d, tilt_pwm_q, tilt_pwm_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == PrescMax);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    us_d    = us_q;
    wpan_d  = wpan_q;
    wtilt_d = wtilt_q;
    if (tick) begin
      if (us_q == UsMax) begin
        us_d    = 16'd0;
        wpan_d  = pan_q;
        wtilt_d = tilt_q;
      end else begin
        us_d = us_q + 16'd1;
      end
    end
    pan_pwm_d  = us_d < {5'd0, wpan_d};
    tilt_pwm_d = us_d < {5'd0, wtilt_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= 16'd0;
      us_q       <= 16'd0;
      wpan_q     <= CenterUs;
      wtilt_q    <= CenterUs;
      pan_pwm_q  <= 1'b0;
      tilt_pwm_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      us_q       <= us_d;
      wpan_q     <= wpan_d;
      wtilt_q    <= wtilt_d;
      pan_pwm_q  <= pan_pwm_d;
      tilt_pwm_q <= tilt_pwm_d;
    end
  end

  assign pan_pwm   = pan_pwm_q;
  assign tilt_pwm  = tilt_pwm_q;
  assign pan_us    = pan_q;
  assign tilt_us   = tilt_q;
  assign state     = st_q;
  assign on_target = on_q;

endmodule

// File: tb/tb_pan_tilt_servo_ctrl.sv
// Directed bench for pan_tilt_servo_ctrl using a short PWM frame
// (2 clk per us, 2200 us per frame) so whole frames can be measured.
module tb_pan_tilt_servo_ctrl;

  localparam int ClkPerUs = 2;
  localparam int PeriodUs = 2200;
  localparam int Frame    = ClkPerUs * PeriodUs;
  localparam int Bound    = 3 * Frame;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync_in;
  logic [9:0]  aim_x, aim_y;
  logic        aim_detected, track_en;
  logic        pan_pwm, tilt_pwm;
  logic [10:0] pan_us, tilt_us;
  logic [1:0]  state;
  logic        on_target;

  int total = 0;
  int bad   = 0;

  pan_tilt_servo_ctrl #(
    .CLK_PER_US(ClkPerUs),
    .PERIOD_US (PeriodUs)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync_in    (vsync_in),
    .aim_x       (aim_x),
    .aim_y       (aim_y),
    .aim_detected(aim_detected),
    .track_en    (track_en),
    .pan_pwm     (pan_pwm),
    .tilt_pwm    (tilt_pwm),
    .pan_us      (pan_us),
    .tilt_us     (tilt_us),
    .state       (state),
    .on_target   (on_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        det;
    logic        en;
    logic [10:0] pan;
    logic [10:0] tilt;
    logic [1:0]  st;
    logic        on;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic ev(input logic [9:0] x, input logic [9:0] y, input logic det, input logic en);
    @(negedge clk);
    aim_x = x; aim_y = y; aim_detected = det; track_en = en;
    repeat (2) @(negedge clk);
    vsync_in = 1'b1;
    repeat (5) @(negedge clk);
    vsync_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic pwm_of(input bit sel);
    return sel ? tilt_pwm : pan_pwm;
  endfunction

  // Measures one full pulse (high cycles and rise-to-rise period); optionally fires
  // a vsync event partway through the high phase.
  task automatic measure(input bit sel, input bit inject, output int hi, output int per);
    int guard;
    hi = 0; per = 0; guard = 0;
    while (pwm_of(sel) == 1'b1 && guard < Bound) begin @(negedge clk); guard++; end
    while (pwm_of(sel) == 1'b0 && guard < Bound) begin @(negedge clk); guard++; end
    while (pwm_of(sel) == 1'b1 && guard < Bound) begin
      if (inject && hi == 100) vsync_in = 1'b1;
      if (inject && hi == 110) vsync_in = 1'b0;
      hi++; guard++;
      @(negedge clk);
    end
    per = hi;
    while (pwm_of(sel) == 1'b0 && guard < Bound) begin per++; guard++; @(negedge clk); end
    if (guard >= Bound) check("pwm_timeout", guard, 0);
  endtask

  initial begin
    int hi, per;
    int prev_pan, prev_tilt;

    tbl[0] = '{x: 336,  y: 224, det: 1, en: 1, pan: 1506, tilt: 1500, st: 0, on: 1};
    tbl[1] = '{x: 320,  y: 240, det: 1, en: 1, pan: 1506, tilt: 1500, st: 0, on: 1};
    tbl[2] = '{x: 0,    y: 479, det: 1, en: 1, pan: 1486, tilt: 1514, st: 0, on: 0};
    tbl[3] = '{x: 337,  y: 240, det: 1, en: 1, pan: 1487, tilt: 1514, st: 0, on: 0};
    tbl[4] = '{x: 303,  y: 257, det: 1, en: 1, pan: 1486, tilt: 1515, st: 0, on: 0};
    tbl[5] = '{x: 320,  y: 240, det: 1, en: 1, pan: 1486, tilt: 1515, st: 0, on: 1};
    tbl[6] = '{x: 1023, y: 0,   det: 1, en: 0, pan: 1486, tilt: 1515, st: 0, on: 0};
    tbl[7] = '{x: 320,  y: 240, det: 0, en: 1, pan: 1486, tilt: 1515, st: 1, on: 0};
    tbl[8] = '{x: 320,  y: 240, det: 1, en: 1, pan: 1486, tilt: 1515, st: 0, on: 1};

    reset = 1'b1; vsync_in = 1'b0; aim_x = 10'd320; aim_y = 10'd240;
    aim_detected = 1'b0; track_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pan_us", pan_us, 1500);
    check("rst_tilt_us", tilt_us, 1500);
    check("rst_state", state, 0);
    check("rst_on_target", on_target, 0);
    check("rst_pan_pwm", pan_pwm, 0);
    check("rst_tilt_pwm", tilt_pwm, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    measure(1'b0, 1'b0, hi, per);
    check("pan_pwm_high", hi, 1500 * ClkPerUs);
    check("pan_pwm_period", per, Frame);
    measure(1'b1, 1'b0, hi, per);
    check("tilt_pwm_high", hi, 1500 * ClkPerUs);

    // First tracking step lands exactly on the third edge after vsync rises
    @(negedge clk);
    aim_x = 10'd420; aim_y = 10'd240; aim_detected = 1'b1;
    repeat (2) @(negedge clk);
    vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    check("step_before_edge3", pan_us, 1500);
    @(negedge clk);
    check("step_pan_edge3", pan_us, 1506);
    check("step_tilt_edge3", tilt_us, 1500);
    check("step_on_target", on_target, 0);
    vsync_in = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      ev(tbl[i].x, tbl[i].y, tbl[i].det, tbl[i].en);
      check($sformatf("vec%0d_pan", i), pan_us, tbl[i].pan);
      check($sformatf("vec%0d_tilt", i), tilt_us, tbl[i].tilt);
      check($sformatf("vec%0d_state", i), state, tbl[i].st);
      check($sformatf("vec%0d_on", i), on_target, tbl[i].on);
    end

    // Saturation: drive hard right/up for 40 frames, no wrap at either limit
    for (int i = 0; i < 40; i++) begin
      prev_pan = pan_us; prev_tilt = tilt_us;
      ev(10'd1023, 10'd0, 1'b1, 1'b1);
      check("sat_pan_monotonic", int'(pan_us >= prev_pan && pan_us <= 2000), 1);
      check("sat_tilt_monotonic", int'(tilt_us <= prev_tilt && tilt_us >= 1000), 1);
    end
    check("sat_pan", pan_us, 2000);
    check("sat_tilt", tilt_us, 1000);

    for (int i = 0; i < 20; i++) ev(10'd0, 10'd600, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) ev(10'd320, 10'd600, 1'b1, 1'b1);
    check("setup_pan", pan_us, 1600);
    check("setup_tilt", tilt_us, 1500);

    // Lost target: 10 lost frames, 5 ignored frames, then 20 more reach the timeout
    ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("lost1_state", state, 1);
    for (int i = 1; i < 10; i++) ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("lost10_state", state, 1);
    check("lost10_pan", pan_us, 1600);
    for (int i = 0; i < 5; i++) ev(10'd420, 10'd240, (i % 2 == 0), 1'b0);
    check("en0_state", state, 1);
    check("en0_pan", pan_us, 1600);
    check("en0_tilt", tilt_us, 1500);
    check("en0_on_target", on_target, 0);
    for (int i = 0; i < 19; i++) ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("lost29_state", state, 1);
    check("lost29_pan", pan_us, 1600);
    ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("lost30_state", state, 2);
    check("lost30_pan", pan_us, 1600);
    ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("return1_pan", pan_us, 1590);
    for (int i = 1; i < 10; i++) ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("return10_pan", pan_us, 1500);
    check("return10_state", state, 2);
    ev(10'd0, 10'd0, 1'b0, 1'b1);
    check("return11_pan", pan_us, 1500);
    check("return11_state", state, 2);
    ev(10'd320, 10'd240, 1'b1, 1'b1);
    check("reacquire_state", state, 0);
    check("reacquire_on", on_target, 1);

    // Mid-pulse position change must not disturb the pulse in flight
    aim_x = 10'd420; aim_y = 10'd240; aim_detected = 1'b1; track_en = 1'b1;
    measure(1'b0, 1'b1, hi, per);
    check("glitch_cur_high", hi, 1500 * ClkPerUs);
    check("glitch_pan_us", pan_us, 1506);
    measure(1'b0, 1'b0, hi, per);
    check("glitch_next_high", hi, 1506 * ClkPerUs);
    check("glitch_next_period", per, Frame);

    // Reset mid-run with vsync already high: no spurious event, pulse starts at once
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_pan_us", pan_us, 1500);
    check("rst2_pwm", pan_pwm, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_pwm_start", pan_pwm, 1);
    repeat (20) @(negedge clk);
    check("rst2_no_event", pan_us, 1500);
    vsync_in = 1'b0;
    repeat (5) @(negedge clk);
    ev(10'd420, 10'd240, 1'b1, 1'b1);
    check("rst2_event_after", pan_us, 1506);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
